// File: rtl/mhsa_pkg.sv
// Shared types and defaults for the MHSA result write-back path.
package mhsa_pkg;

    localparam int unsigned WB_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mhsa_wb_fifo.sv
// Two-entry FIFO decoupling bar SRAM read data from the external write port.
module mhsa_wb_fifo #(
    parameter int unsigned WIDTH = mhsa_pkg::WB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head word and occupancy flags.
    always_comb begin
        head  = mem[rd_ptr];
        empty = (count == 2'd0);
        full  = (count == 2'd2);
    end

endmodule

// File: rtl/mhsa_writeback.sv
// Streams NUM_WORDS result words from the bar SRAM to an external
// valid/ready write port at consecutive byte addresses from output_base.
module mhsa_writeback #(
    parameter int unsigned WIDTH     = mhsa_pkg::WB_WIDTH_DEFAULT,
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned SRC_BASE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             done,
    input  logic [31:0]      output_base,
    output logic [31:0]      sram_addr,
    input  logic [WIDTH-1:0] sram_data_out,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [31:0]      wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             wr_last
);
    import mhsa_pkg::*;

    localparam logic [16:0] WORDS    = 17'(NUM_WORDS);
    localparam logic [16:0] LAST_IDX = 17'(NUM_WORDS - 1);
    localparam logic [31:0] BYTES    = 32'(WIDTH / 8);
    localparam logic [31:0] SRC      = 32'(SRC_BASE);

    wb_state_t        state_q, state_d;
    logic [31:0]      base_q;
    logic [31:0]      sram_addr_q;
    logic [31:0]      rd_addr;
    logic [16:0]      rd_idx_q;
    logic [16:0]      wr_idx_q;
    logic             inflight_q;
    logic [1:0]       fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_head;
    logic             accept;
    logic             issue;
    logic             pop;
    logic             last_hs;
    logic [2:0]       occupancy;

    // Handshake and read-issue qualifiers shared by the FSM and the datapath.
    always_comb begin
        accept    = (state_q == IDLE) && start;
        pop       = !fifo_empty && wr_ready;
        last_hs   = pop && (wr_idx_q == LAST_IDX);
        // a pop this cycle frees its slot before the new read returns, so it
        // is credited here; this keeps one word per cycle without overflow
        occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == RUN) && (rd_idx_q < WORDS) && (occupancy < 3'd2);
        rd_addr   = SRC + 32'(rd_idx_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start is only looked at in IDLE and (to leave) in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = RUN;
            RUN:     if (last_hs) state_d = DONE;
            DONE:    if (!start)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched base, read/write indices, inflight flag and held read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            inflight_q  <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                base_q   <= output_base;
                rd_idx_q <= '0;
                wr_idx_q <= '0;
            end else begin
                if (issue) rd_idx_q <= rd_idx_q + 17'd1;
                if (pop)   wr_idx_q <= wr_idx_q + 17'd1;
            end
            if (issue) begin
                sram_addr_q <= rd_addr;
            end else if (state_d != RUN) begin
                sram_addr_q <= '0;
            end
        end
    end

    // Outputs: write port is gated by FIFO occupancy so it reads zero when idle.
    always_comb begin
        done      = (state_q == DONE);
        sram_addr = issue ? rd_addr : sram_addr_q;
        wr_valid  = !fifo_empty;
        wr_data   = wr_valid ? fifo_head : '0;
        wr_addr   = wr_valid ? (base_q + 32'(wr_idx_q) * BYTES) : '0;
        wr_last   = wr_valid && (wr_idx_q == LAST_IDX);
    end

    mhsa_wb_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_data(sram_data_out),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // A returning read must always find a free FIFO slot.
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && inflight_q));

endmodule

// File: doc/mhsa_writeback.md
MHSA_WRITEBACK -- requirements
Module: mhsa_writeback

Interface
REQ-001 Parameter WIDTH, default 64: SRAM/bus word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NUM_WORDS, default 256: result words per transfer; range 1..65535.
REQ-003 Parameter SRC_BASE, default 0: first bar word address holding the result.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  level request; sampled only in IDLE.
REQ-007 done  output  1  transfer complete; held until start deasserts.
REQ-008 output_base  input  32  external byte base address; latched when start is accepted.
REQ-009 sram_addr  output  32  bar read word address.
REQ-010 sram_data_out  input  WIDTH  bar read data, valid one cycle after sram_addr.
REQ-011 wr_valid  output  1  external write request.
REQ-012 wr_ready  input  1  external write accept.
REQ-013 wr_addr  output  32  external byte address.
REQ-014 wr_data  output  WIDTH  external write data.
REQ-015 wr_last  output  1  marks word NUM_WORDS-1.

Function
REQ-016 The FSM SHALL use states IDLE, RUN and DONE.
- IDLE->RUN when start=1; latch output_base; clear rd_idx and wr_idx.
- RUN->DONE on the handshake of word NUM_WORDS-1.
- DONE->IDLE when start=0.
REQ-017 done SHALL be 1 only in DONE; start=1 in RUN or DONE SHALL be ignored.
REQ-018 In RUN, a read SHALL issue in any cycle where rd_idx<NUM_WORDS and fifo_count+inflight<2.
- Read drives sram_addr=SRC_BASE+rd_idx, then increments rd_idx.
- Otherwise sram_addr SHALL hold its last value; it SHALL be 0 in IDLE and DONE.
REQ-019 Read data SHALL be pushed into a 2-entry FIFO the cycle after issue (inflight flag); the FIFO SHALL never overflow.
REQ-020 wr_valid SHALL equal FIFO non-empty.
- wr_data = FIFO head.
- wr_addr = latched_base + wr_idx*(WIDTH/8), modulo 2^32 (wrap, no error).
- wr_last = (wr_idx==NUM_WORDS-1).
REQ-021 Once wr_valid=1, wr_valid/wr_addr/wr_data/wr_last SHALL remain stable until wr_ready=1.
REQ-022 On wr_valid&wr_ready, the FIFO SHALL pop and wr_idx SHALL increment; simultaneous push and pop SHALL keep the count unchanged.
REQ-023 Latency:
- start accepted at edge T: first sram_addr at T+1, first wr_valid at T+2.
- With wr_ready held 1: one word per cycle; done=1 at T+NUM_WORDS+2.
REQ-024 The block SHALL never write the bar SRAM; no sram write-enable port exists.

Reset
REQ-025 On rst_n=0, at any time including mid-RUN, the block SHALL immediately force:
- state=IDLE, done=0, wr_valid=0, wr_last=0.
- wr_addr=0, wr_data=0, sram_addr=0.
- FIFO empty, inflight=0, rd_idx=0, wr_idx=0, latched base=0.
REQ-026 After reset release, no transfer SHALL start until start is sampled 1 in IDLE.

Structure
REQ-027 The shared mhsa_pkg SHALL hold the wb_state_t enum (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-028 The 2-entry FIFO SHALL be a sub-module mhsa_wb_fifo (push, pop, data, count, empty/full); the top SHALL hold the FSM, counters and address generation.

Verification
REQ-029 NUM_WORDS=4, output_base=0x1000, wr_ready=1, SRAM word n=0xA0+n:
- expect 4 handshakes at 0x1000/0x1008/0x1010/0x1018 with data 0xA0..0xA3;
- wr_last on the 4th handshake; done at T+6.
REQ-030 wr_ready=0 for 3 cycles while word 1 is pending:
- wr_addr=0x1008 and data stable throughout;
- no more than 2 reads outstanding;
- final data order intact.
REQ-031 output_base=0xFFFF_FFF0, NUM_WORDS=4 -> addresses 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
REQ-032 rst_n pulsed low after word 2 handshake:
- all outputs 0 within the reset;
- restart with start=1 -> transfer begins again at word 0.
REQ-033 start held 1 after done: done stays 1; start drops -> IDLE next cycle, done=0; start re-asserted mid-RUN has no effect.
REQ-034 NUM_WORDS=1 -> single handshake with wr_last=1, then done.
